vrf_operand_collector: RTL and testbench
========================================

Name: vrf_operand_collector

Overview:
- Downstream of vector_regfile: consumes per-port read-return data (vld, rs_idx, rs_field_idx, data) and assembles up to three source operands per reservation-station entry.
- Issues an entry to the vector FU over a valid/ready handshake once every required field has arrived.
- Also allocates the entry index that upstream uses to tag its register-file read requests.

Parameters:
- RPORT_NUM, 5, number of register-file read-return ports.
- ENT_NUM, 8, collector entries.
- IDX_W, 3, entry index width (clog2 ENT_NUM).
- VFULEN, 64, operand data width per field.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all entries
- alloc_vld  input  1  allocation request
- alloc_need  input  3  required-field mask; bit0 = vs1, bit1 = vs2, bit2 = vs3
- alloc_rdy  output  1  a free entry exists
- alloc_idx  output  IDX_W  entry granted (lowest-index free entry)
- ret_vld  input  RPORT_NUM  per-port return valid
- ret_idx  input  RPORT_NUM*IDX_W  per-port entry tag
- ret_field  input  RPORT_NUM*2  per-port field index (0..2; 3 illegal)
- ret_data  input  RPORT_NUM*VFULEN  per-port data
- iss_vld  output  1  an entry is ready
- iss_rdy  input  1  FU accepts
- iss_idx  output  IDX_W  issuing entry
- iss_src1, iss_src2, iss_src3  output  VFULEN each  operand fields
- occ_cnt  output  IDX_W+1  number of non-FREE entries
- err  output  1  sticky protocol error

Behaviour:
- Clock and reset: one clock clk; reset rstn is asynchronous, active-low.
- Reset values: all entries FREE, alloc_rdy=1, alloc_idx=0, iss_vld=0, iss_idx=0, iss_src*=0, occ_cnt=0, err=0. Entry data registers are not reset.
- Per-entry state machine:
  - FREE -> COLLECT on accepted alloc (alloc_vld & alloc_rdy); need mask latched, got mask cleared.
  - COLLECT -> READY when (got & need) == need, evaluated on registered state.
  - Allocation with alloc_need=0 enters COLLECT and becomes READY the following cycle.
  - READY -> FREE on iss_vld & iss_rdy for that entry.
- alloc_rdy and alloc_idx are combinational from current entry state. An entry freed by issue in cycle N is allocatable from N+1 (no same-cycle reuse).
- Capture, for each port p with ret_vld[p]:
  - Write ret_data[p] into field ret_field[p] of entry ret_idx[p] and set the got bit at the clock edge.
  - Capture is also accepted when the entry is READY (overwrite of a held field); the got bit is unchanged.
  - Multiple ports hitting the same entry and field in one cycle: the highest port index wins.
  - Different fields of the same entry in one cycle are all captured.
- Capture latency: last required field returned in cycle N -> iss_vld high in N+1 with that data on iss_src*.
- Errors: a return to a FREE entry, or ret_field==3, is dropped and sets err. err clears only on reset; flush does not clear it.
- Issue:
  - iss_vld is high when any entry is READY; selection is the lowest-index READY entry (combinational mux).
  - Fields not in the entry's need mask are driven as 0.
  - All iss_* outputs are 0 when iss_vld=0.
  - The selected entry is held stable while iss_rdy=0 unless a lower-index entry becomes READY; switching selection before acceptance is legal.
- occ_cnt counts entries in COLLECT or READY, registered. Simultaneous alloc and issue leave it unchanged.
- Full: with all entries non-FREE, alloc_rdy=0 and alloc_vld is ignored.
- Flush:
  - Takes priority over alloc, capture and issue in the same cycle; all entries become FREE next cycle, occ_cnt=0.
  - iss_vld still reflects pre-flush state during the flush cycle, but the issue is not counted as accepted.
- Reset asserted mid-operation: immediate return to the reset values, with no partial captures retained.

Test Plan:
- Reset, then alloc_vld=1, need=3'b011 -> alloc_idx=0, occ_cnt=1. Port0 returns idx0 field0 data 0xA5; port3 returns idx0 field1 data 0x5A in the same cycle -> next cycle iss_vld=1, iss_idx=0, src1=0xA5, src2=0x5A, src3=0. With iss_rdy=1 -> occ_cnt=0.
- Allocate 8 entries back-to-back -> alloc_idx 0..7, occ_cnt=8, alloc_rdy=0. A 9th alloc_vld is ignored. Issue entry 2 -> alloc_rdy=1 the next cycle with alloc_idx=2.
- Ports 1 and 4 write idx0 field2 in one cycle with 0x11 and 0x22 -> src3=0x22 at issue.
- Entries 5 and 1 become READY in the same cycle with iss_rdy=0 for 3 cycles -> iss_idx=1 held for 3 cycles. iss_rdy=1 -> entry 1 issues, then entry 5 is presented the next cycle.
- Return to FREE entry 6, or ret_field=3 -> no state change, err=1 and it stays 1 through a later flush.
- Flush asserted in the same cycle as alloc_vld and a completing return -> occ_cnt=0, iss_vld=0 next cycle. Also: rstn dropped mid-collect -> all outputs at reset values immediately.

Source files
------------

// File: rtl/vrf_operand_collector_if.sv
// rtl/vrf_operand_collector_if.sv - allocation, read-return and issue bundle for the operand collector
interface vrf_operand_collector_if #(
    parameter int RPORT_NUM = 5,
    parameter int IDX_W     = 3,
    parameter int VFULEN    = 64
);
    logic                        flush;
    logic                        alloc_vld;
    logic [2:0]                  alloc_need;
    logic                        alloc_rdy;
    logic [IDX_W-1:0]            alloc_idx;
    logic [RPORT_NUM-1:0]        ret_vld;
    logic [RPORT_NUM*IDX_W-1:0]  ret_idx;
    logic [RPORT_NUM*2-1:0]      ret_field;
    logic [RPORT_NUM*VFULEN-1:0] ret_data;
    logic                        iss_vld;
    logic                        iss_rdy;
    logic [IDX_W-1:0]            iss_idx;
    logic [VFULEN-1:0]           iss_src1;
    logic [VFULEN-1:0]           iss_src2;
    logic [VFULEN-1:0]           iss_src3;
    logic [IDX_W:0]              occ_cnt;
    logic                        err;

    modport master (
        output flush, alloc_vld, alloc_need, ret_vld, ret_idx, ret_field, ret_data, iss_rdy,
        input  alloc_rdy, alloc_idx, iss_vld, iss_idx, iss_src1, iss_src2, iss_src3, occ_cnt, err
    );

    modport slave (
        input  flush, alloc_vld, alloc_need, ret_vld, ret_idx, ret_field, ret_data, iss_rdy,
        output alloc_rdy, alloc_idx, iss_vld, iss_idx, iss_src1, iss_src2, iss_src3, occ_cnt, err
    );
endinterface

// File: rtl/vrf_operand_collector.sv
// rtl/vrf_operand_collector.sv - gathers register-file read returns into entries and issues complete ones to the vector FU
module vrf_operand_collector #(
    parameter int RPORT_NUM = 5,
    parameter int ENT_NUM   = 8,
    parameter int IDX_W     = 3,
    parameter int VFULEN    = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    vrf_operand_collector_if.slave  bus
);
    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    logic [1:0]        st_q   [ENT_NUM];
    logic [2:0]        need_q [ENT_NUM];
    logic [2:0]        got_q  [ENT_NUM];
    logic [VFULEN-1:0] data_q [ENT_NUM][3];
    logic [IDX_W:0]    occ_q;
    logic              err_q;

    logic              alloc_rdy_c;
    logic [IDX_W-1:0]  alloc_idx_c;
    logic              iss_vld_c;
    logic [IDX_W-1:0]  iss_idx_c;
    logic [VFULEN-1:0] src1_c, src2_c, src3_c;
    logic              alloc_fire;
    logic              iss_fire;

    logic [IDX_W-1:0]  p_idx [RPORT_NUM];
    logic [1:0]        p_fld [RPORT_NUM];
    logic [VFULEN-1:0] p_dat [RPORT_NUM];
    logic [RPORT_NUM-1:0] p_free;
    logic [2:0]        wr_en  [ENT_NUM];
    logic [VFULEN-1:0] wr_dat [ENT_NUM][3];
    logic              ret_bad;

    // Lowest-index free entry wins the grant; descending scan leaves the smallest index last.
    always_comb begin
        alloc_rdy_c = 1'b0;
        alloc_idx_c = '0;
        for (int e = ENT_NUM - 1; e >= 0; e--) begin
            if (st_q[e] == ST_FREE) begin
                alloc_rdy_c = 1'b1;
                alloc_idx_c = IDX_W'(e);
            end
        end
    end

    always_comb begin
        iss_vld_c = 1'b0;
        iss_idx_c = '0;
        for (int e = ENT_NUM - 1; e >= 0; e--) begin
            if (st_q[e] == ST_READY) begin
                iss_vld_c = 1'b1;
                iss_idx_c = IDX_W'(e);
            end
        end
    end

    always_comb begin
        src1_c = '0;
        src2_c = '0;
        src3_c = '0;
        for (int e = 0; e < ENT_NUM; e++) begin
            if (iss_vld_c && (iss_idx_c == IDX_W'(e))) begin
                if (need_q[e][0]) src1_c = data_q[e][0];
                if (need_q[e][1]) src2_c = data_q[e][1];
                if (need_q[e][2]) src3_c = data_q[e][2];
            end
        end
    end

    assign alloc_fire = bus.alloc_vld && alloc_rdy_c && !bus.flush;
    assign iss_fire   = iss_vld_c && bus.iss_rdy && !bus.flush;

    always_comb begin
        for (int p = 0; p < RPORT_NUM; p++) begin
            p_idx[p] = bus.ret_idx[p*IDX_W +: IDX_W];
            p_fld[p] = bus.ret_field[p*2 +: 2];
            p_dat[p] = bus.ret_data[p*VFULEN +: VFULEN];
        end
    end

    // A tag that matches no entry is treated like a FREE target.
    always_comb begin
        for (int p = 0; p < RPORT_NUM; p++) begin
            p_free[p] = 1'b1;
            for (int e = 0; e < ENT_NUM; e++) begin
                if (p_idx[p] == IDX_W'(e)) p_free[p] = (st_q[e] == ST_FREE);
            end
        end
    end

    // Ports are scanned upward so the highest port hitting a field overrides lower ones.
    always_comb begin
        ret_bad = 1'b0;
        for (int e = 0; e < ENT_NUM; e++) begin
            wr_en[e] = 3'b000;
            for (int f = 0; f < 3; f++) wr_dat[e][f] = '0;
        end
        for (int p = 0; p < RPORT_NUM; p++) begin
            if (bus.ret_vld[p]) begin
                if ((p_fld[p] == 2'd3) || p_free[p]) begin
                    ret_bad = 1'b1;
                end else if (!bus.flush) begin
                    for (int e = 0; e < ENT_NUM; e++) begin
                        for (int f = 0; f < 3; f++) begin
                            if ((p_idx[p] == IDX_W'(e)) && (p_fld[p] == 2'(f))) begin
                                wr_en[e][f]  = 1'b1;
                                wr_dat[e][f] = p_dat[p];
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < ENT_NUM; e++) begin
                st_q[e]   <= ST_FREE;
                need_q[e] <= 3'b000;
                got_q[e]  <= 3'b000;
            end
            occ_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (ret_bad) err_q <= 1'b1;
            if (bus.flush) begin
                for (int e = 0; e < ENT_NUM; e++) st_q[e] <= ST_FREE;
                occ_q <= '0;
            end else begin
                for (int e = 0; e < ENT_NUM; e++) begin
                    case (st_q[e])
                        ST_FREE: begin
                            if (alloc_fire && (alloc_idx_c == IDX_W'(e))) begin
                                st_q[e]   <= ST_COLLECT;
                                need_q[e] <= bus.alloc_need;
                                got_q[e]  <= 3'b000;
                            end
                        end
                        ST_COLLECT: begin
                            got_q[e] <= got_q[e] | wr_en[e];
                            // Include this cycle's returns so the last field shows up at issue one cycle later.
                            if (((got_q[e] | wr_en[e]) & need_q[e]) == need_q[e]) st_q[e] <= ST_READY;
                        end
                        ST_READY: begin
                            if (iss_fire && (iss_idx_c == IDX_W'(e))) st_q[e] <= ST_FREE;
                        end
                        default: st_q[e] <= ST_FREE;
                    endcase
                end
                occ_q <= occ_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(iss_fire);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < ENT_NUM; e++) begin
            for (int f = 0; f < 3; f++) begin
                if (wr_en[e][f]) data_q[e][f] <= wr_dat[e][f];
            end
        end
    end

    assign bus.alloc_rdy = alloc_rdy_c;
    assign bus.alloc_idx = alloc_idx_c;
    assign bus.iss_vld   = iss_vld_c;
    assign bus.iss_idx   = iss_idx_c;
    assign bus.iss_src1  = src1_c;
    assign bus.iss_src2  = src2_c;
    assign bus.iss_src3  = src3_c;
    assign bus.occ_cnt   = occ_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_vrf_operand_collector.sv
// tb/tb_vrf_operand_collector.sv - directed vector table plus hand sequences for the operand collector
module tb_vrf_operand_collector;
    logic clk;
    logic rstn;
    int   total;
    int   bad;

    vrf_operand_collector_if #(.RPORT_NUM(5), .IDX_W(3), .VFULEN(64)) bus ();

    vrf_operand_collector #(.RPORT_NUM(5), .ENT_NUM(8), .IDX_W(3), .VFULEN(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       alloc_vld;
        logic [2:0] need;
        logic       iss_rdy;
        logic       a_en;
        logic [2:0] a_port;
        logic [2:0] a_idx;
        logic [1:0] a_fld;
        logic [7:0] a_dat;
        logic       b_en;
        logic [2:0] b_port;
        logic [2:0] b_idx;
        logic [1:0] b_fld;
        logic [7:0] b_dat;
        logic       e_ardy;
        logic [2:0] e_aidx;
        logic       e_ivld;
        logic [2:0] e_iidx;
        logic [7:0] e_s1;
        logic [7:0] e_s2;
        logic [7:0] e_s3;
        logic [3:0] e_occ;
    } vec_t;

    vec_t vt [14];

    function automatic vec_t mk(input int av, nd, ir, ae, ap, ai, af, ad, be, bp, bi, bf, bd,
                                input int ardy, aidx, ivld, iidx, s1, s2, s3, occ);
        vec_t r;
        r.alloc_vld = 1'(av);  r.need   = 3'(nd);   r.iss_rdy = 1'(ir);
        r.a_en   = 1'(ae);     r.a_port = 3'(ap);   r.a_idx = 3'(ai); r.a_fld = 2'(af); r.a_dat = 8'(ad);
        r.b_en   = 1'(be);     r.b_port = 3'(bp);   r.b_idx = 3'(bi); r.b_fld = 2'(bf); r.b_dat = 8'(bd);
        r.e_ardy = 1'(ardy);   r.e_aidx = 3'(aidx); r.e_ivld = 1'(ivld); r.e_iidx = 3'(iidx);
        r.e_s1   = 8'(s1);     r.e_s2   = 8'(s2);   r.e_s3 = 8'(s3);  r.e_occ = 4'(occ);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.flush      = 1'b0;
        bus.alloc_vld  = 1'b0;
        bus.alloc_need = 3'b000;
        bus.iss_rdy    = 1'b0;
        bus.ret_vld    = '0;
        bus.ret_idx    = '0;
        bus.ret_field  = '0;
        bus.ret_data   = '0;
    endtask

    task automatic put_ret(input int p, input int idx, input int fld, input logic [63:0] d);
        bus.ret_vld[p]             = 1'b1;
        bus.ret_idx[p*3 +: 3]      = 3'(idx);
        bus.ret_field[p*2 +: 2]    = 2'(fld);
        bus.ret_data[p*64 +: 64]   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive_idle();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("rst_ardy", 64'(bus.alloc_rdy), 1);
        chk("rst_aidx", 64'(bus.alloc_idx), 0);
        chk("rst_ivld", 64'(bus.iss_vld), 0);
        chk("rst_iidx", 64'(bus.iss_idx), 0);
        chk("rst_src1", bus.iss_src1, 0);
        chk("rst_occ",  64'(bus.occ_cnt), 0);
        chk("rst_err",  64'(bus.err), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        //            av nd    ir  a:en p i f dat    b:en p i f dat   | ardy aidx ivld iidx s1    s2    s3    occ
        vt[0]  = mk(1, 3'b011, 0,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 0, 0, 0, 0,    0,    0,    0);
        vt[1]  = mk(0, 0,      0,  1, 0, 0, 0, 'hA5,  1, 3, 0, 1, 'h5A,  1, 1, 0, 0, 0,    0,    0,    1);
        vt[2]  = mk(0, 0,      1,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 1, 1, 0, 'hA5, 'h5A, 0,    1);
        vt[3]  = mk(1, 3'b100, 0,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 0, 0, 0, 0,    0,    0,    0);
        vt[4]  = mk(0, 0,      0,  1, 1, 0, 2, 'h11,  1, 4, 0, 2, 'h22,  1, 1, 0, 0, 0,    0,    0,    1);
        vt[5]  = mk(0, 0,      0,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 1, 1, 0, 0,    0,    'h22, 1);
        vt[6]  = mk(0, 0,      1,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 1, 1, 0, 0,    0,    'h22, 1);
        vt[7]  = mk(1, 3'b000, 0,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 0, 0, 0, 0,    0,    0,    0);
        vt[8]  = mk(0, 0,      0,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 1, 0, 0, 0,    0,    0,    1);
        vt[9]  = mk(0, 0,      1,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 1, 1, 0, 0,    0,    0,    1);
        vt[10] = mk(1, 3'b001, 0,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 0, 0, 0, 0,    0,    0,    0);
        vt[11] = mk(0, 0,      0,  1, 4, 0, 0, 'h33,  1, 2, 0, 0, 'h44,  1, 1, 0, 0, 0,    0,    0,    1);
        vt[12] = mk(0, 0,      1,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 1, 1, 0, 'h33, 0,    0,    1);
        vt[13] = mk(0, 0,      0,  0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     1, 0, 0, 0, 0,    0,    0,    0);

        for (int i = 0; i < 14; i++) begin
            drive_idle();
            bus.alloc_vld  = vt[i].alloc_vld;
            bus.alloc_need = vt[i].need;
            bus.iss_rdy    = vt[i].iss_rdy;
            if (vt[i].a_en) put_ret(int'(vt[i].a_port), int'(vt[i].a_idx), int'(vt[i].a_fld), 64'(vt[i].a_dat));
            if (vt[i].b_en) put_ret(int'(vt[i].b_port), int'(vt[i].b_idx), int'(vt[i].b_fld), 64'(vt[i].b_dat));
            #1;
            chk($sformatf("v%0d_ardy", i), 64'(bus.alloc_rdy), 64'(vt[i].e_ardy));
            chk($sformatf("v%0d_aidx", i), 64'(bus.alloc_idx), 64'(vt[i].e_aidx));
            chk($sformatf("v%0d_ivld", i), 64'(bus.iss_vld),   64'(vt[i].e_ivld));
            chk($sformatf("v%0d_iidx", i), 64'(bus.iss_idx),   64'(vt[i].e_iidx));
            chk($sformatf("v%0d_src1", i), bus.iss_src1,       64'(vt[i].e_s1));
            chk($sformatf("v%0d_src2", i), bus.iss_src2,       64'(vt[i].e_s2));
            chk($sformatf("v%0d_src3", i), bus.iss_src3,       64'(vt[i].e_s3));
            chk($sformatf("v%0d_occ", i),  64'(bus.occ_cnt),   64'(vt[i].e_occ));
            chk($sformatf("v%0d_err", i),  64'(bus.err),       0);
            tick();
        end

        // fill all eight entries, then free entry 2
        for (int i = 0; i < 8; i++) begin
            drive_idle();
            bus.alloc_vld  = 1'b1;
            bus.alloc_need = 3'b001;
            #1;
            chk("full_aidx", 64'(bus.alloc_idx), 64'(i));
            chk("full_ardy", 64'(bus.alloc_rdy), 1);
            tick();
        end
        drive_idle(); bus.alloc_vld = 1'b1; bus.alloc_need = 3'b001; #1;
        chk("full_ardy0", 64'(bus.alloc_rdy), 0);
        chk("full_occ8",  64'(bus.occ_cnt), 8);
        tick();
        drive_idle(); put_ret(0, 2, 0, 'h77); #1;
        chk("full_ninth_ignored", 64'(bus.occ_cnt), 8);
        tick();
        drive_idle(); bus.iss_rdy = 1'b1; #1;
        chk("full_ivld",  64'(bus.iss_vld), 1);
        chk("full_iidx",  64'(bus.iss_idx), 2);
        chk("full_src1",  bus.iss_src1, 'h77);
        chk("full_noreuse", 64'(bus.alloc_rdy), 0);
        tick();
        drive_idle(); #1;
        chk("reuse_ardy", 64'(bus.alloc_rdy), 1);
        chk("reuse_aidx", 64'(bus.alloc_idx), 2);
        chk("reuse_occ",  64'(bus.occ_cnt), 7);

        // entries 5 and 1 complete together; lower index is held until accepted
        drive_idle(); put_ret(0, 5, 0, 'h55); put_ret(1, 1, 0, 'h11); #1;
        tick();
        for (int k = 0; k < 3; k++) begin
            drive_idle(); #1;
            chk("tie_ivld", 64'(bus.iss_vld), 1);
            chk("tie_hold", 64'(bus.iss_idx), 1);
            chk("tie_src1", bus.iss_src1, 'h11);
            tick();
        end
        drive_idle(); bus.iss_rdy = 1'b1; #1;
        chk("tie_acc1", 64'(bus.iss_idx), 1);
        tick();
        drive_idle(); bus.iss_rdy = 1'b1; #1;
        chk("tie_next5", 64'(bus.iss_idx), 5);
        chk("tie_src5",  bus.iss_src1, 'h55);
        tick();
        drive_idle(); #1;
        chk("tie_occ",  64'(bus.occ_cnt), 5);
        chk("tie_aidx", 64'(bus.alloc_idx), 1);
        chk("tie_idle", 64'(bus.iss_vld), 0);

        // illegal field index on a collecting entry
        chk("fld3_err_before", 64'(bus.err), 0);
        put_ret(0, 0, 3, 'h1); #1;
        tick();
        drive_idle(); #1;
        chk("fld3_err",   64'(bus.err), 1);
        chk("fld3_nocap", 64'(bus.iss_vld), 0);
        chk("fld3_occ",   64'(bus.occ_cnt), 5);

        // flush beats a same-cycle alloc and completing return
        drive_idle(); bus.flush = 1'b1; bus.alloc_vld = 1'b1; bus.alloc_need = 3'b000;
        put_ret(0, 0, 0, 'h5); #1;
        tick();
        drive_idle(); #1;
        chk("flush_occ",  64'(bus.occ_cnt), 0);
        chk("flush_ivld", 64'(bus.iss_vld), 0);
        chk("flush_aidx", 64'(bus.alloc_idx), 0);
        chk("flush_err_kept", 64'(bus.err), 1);
        tick();
        drive_idle(); #1;
        chk("flush_noalloc", 64'(bus.iss_vld), 0);

        // reset mid-collect drops the partial capture
        drive_idle(); bus.alloc_vld = 1'b1; bus.alloc_need = 3'b011; #1;
        tick();
        drive_idle(); put_ret(0, 0, 0, 'h99); #1;
        tick();
        drive_idle(); #1;
        chk("mid_half", 64'(bus.iss_vld), 0);
        rstn = 1'b0;
        #1;
        chk("mid_occ",  64'(bus.occ_cnt), 0);
        chk("mid_ardy", 64'(bus.alloc_rdy), 1);
        chk("mid_aidx", 64'(bus.alloc_idx), 0);
        chk("mid_ivld", 64'(bus.iss_vld), 0);
        chk("mid_iidx", 64'(bus.iss_idx), 0);
        chk("mid_src1", bus.iss_src1, 0);
        chk("mid_err",  64'(bus.err), 0);
        @(negedge clk);
        rstn = 1'b1;
        drive_idle(); bus.alloc_vld = 1'b1; bus.alloc_need = 3'b011; #1;
        tick();
        drive_idle(); put_ret(1, 0, 1, 'hBB); #1;
        tick();
        drive_idle(); #1;
        chk("mid_nostale", 64'(bus.iss_vld), 0);
        put_ret(0, 0, 0, 'hCC); #1;
        tick();
        drive_idle(); bus.iss_rdy = 1'b1; #1;
        chk("mid_done_ivld", 64'(bus.iss_vld), 1);
        chk("mid_done_src1", bus.iss_src1, 'hCC);
        chk("mid_done_src2", bus.iss_src2, 'hBB);
        tick();

        // return to a FREE entry; err survives a flush
        drive_idle(); #1;
        chk("free_err_before", 64'(bus.err), 0);
        put_ret(2, 6, 0, 'h1); #1;
        tick();
        drive_idle(); #1;
        chk("free_err",  64'(bus.err), 1);
        chk("free_occ",  64'(bus.occ_cnt), 0);
        chk("free_ivld", 64'(bus.iss_vld), 0);
        bus.flush = 1'b1;
        tick();
        drive_idle(); #1;
        chk("free_err_sticky", 64'(bus.err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
